// File: rtl/sha256_block_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha256_block_controller_pkg
// Purpose  : Shared SHA-256 definitions for the block controller, message
//            scheduler and compression core. Contains the controller state
//            encoding, the round count, the H0..H7 initial hash values and the
//            K[0:63] round-constant table.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sha256_block_controller_pkg;

  localparam int SHA_ROUNDS    = 64;
  localparam int ROUND_IDX_W   = $clog2(SHA_ROUNDS);
  localparam int BLOCK_COUNT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BLK = 3'd1,
    ST_LOAD     = 3'd2,
    ST_ROUNDS   = 3'd3,
    ST_UPDATE   = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Initial hash value; element 0 is H0.
  localparam logic [0:7][31:0] H0_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round constants; element 0 is K[0].
  localparam logic [0:63][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Round-constant lookup indexed directly by round_idx.
  function automatic logic [31:0] k_const(input logic [ROUND_IDX_W-1:0] idx);
    return K_TABLE[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_block_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_block_controller_if
// Purpose  : Control bundle between the host-side block buffer / datapath and
//            the SHA-256 block controller.
// Ports    : master modport - drives start, block_count, abort, blk_valid,
//                             digest_ack; observes all controller outputs.
//            slave modport  - the controller: observes the host inputs and
//                             drives blk_ready, sched_load, init_hash,
//                             round_en, round_idx, hash_update, digest_valid,
//                             busy, err_count0.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_block_controller_if #(
  parameter int BC_W = 2
);
  import sha256_block_controller_pkg::*;

  logic                   start;
  logic [BC_W-1:0]        block_count;
  logic                   abort;
  logic                   blk_valid;
  logic                   blk_ready;
  logic                   sched_load;
  logic                   init_hash;
  logic                   round_en;
  logic [ROUND_IDX_W-1:0] round_idx;
  logic                   hash_update;
  logic                   digest_valid;
  logic                   digest_ack;
  logic                   busy;
  logic                   err_count0;

  modport master (
    output start, block_count, abort, blk_valid, digest_ack,
    input  blk_ready, sched_load, init_hash, round_en, round_idx,
           hash_update, digest_valid, busy, err_count0
  );

  modport slave (
    input  start, block_count, abort, blk_valid, digest_ack,
    output blk_ready, sched_load, init_hash, round_en, round_idx,
           hash_update, digest_valid, busy, err_count0
  );

endinterface
`default_nettype wire

// File: rtl/sha256_block_controller.sv
`default_nettype none
// ============================================================================
// Module   : sha256_block_controller
// Purpose  : Sequences one SHA-256 hash over 1..2**BC_W-1 pre-padded blocks:
//            accepts each block by valid/ready, strobes the message scheduler
//            load, steps the compression core through ROUNDS rounds, commits
//            the hash update and finally holds digest_valid until acknowledged.
// Ports    : clk   - clock, all state on the rising edge
//            reset - asynchronous active-low reset
//            bus   - sha256_block_controller_if.slave control bundle
// Revision : 1.0 - initial release
// ============================================================================
module sha256_block_controller
  import sha256_block_controller_pkg::*;
#(
  parameter int ROUNDS    = SHA_ROUNDS,
  parameter int SCHED_LAT = 1,
  parameter int BC_W      = BLOCK_COUNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  sha256_block_controller_if.slave    bus
);

  localparam int                     LAT_W    = (SCHED_LAT > 1) ? $clog2(SCHED_LAT) : 1;
  localparam logic [LAT_W-1:0]       LAT_LAST = LAT_W'(SCHED_LAT - 1);
  localparam logic [ROUND_IDX_W-1:0] IDX_LAST = ROUND_IDX_W'(ROUNDS - 1);

  state_t                 r_state;
  logic [BC_W-1:0]        r_blocks_left;
  logic                   r_first;
  logic [LAT_W-1:0]       r_lat_cnt;

  logic                   r_blk_ready;
  logic                   r_sched_load;
  logic                   r_init_hash;
  logic                   r_round_en;
  logic [ROUND_IDX_W-1:0] r_round_idx;
  logic                   r_hash_update;
  logic                   r_digest_valid;
  logic                   r_busy;
  logic                   r_err_count0;

  // Every output is loaded together with the state that owns it, so each
  // output is a flop with no combinational path from any input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_blocks_left  <= '0;
      r_first        <= 1'b0;
      r_lat_cnt      <= '0;
      r_blk_ready    <= 1'b0;
      r_sched_load   <= 1'b0;
      r_init_hash    <= 1'b0;
      r_round_en     <= 1'b0;
      r_round_idx    <= '0;
      r_hash_update  <= 1'b0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_err_count0   <= 1'b0;
    end else begin
      // Single-cycle strobes fall back to zero unless re-armed below.
      r_sched_load  <= 1'b0;
      r_init_hash   <= 1'b0;
      r_hash_update <= 1'b0;
      r_err_count0  <= 1'b0;

      // Abort outranks every same-cycle event, including the last round
      // (no hash_update) and digest_ack.
      if ((r_state != ST_IDLE) && bus.abort) begin
        r_state        <= ST_IDLE;
        r_blocks_left  <= '0;
        r_first        <= 1'b0;
        r_lat_cnt      <= '0;
        r_blk_ready    <= 1'b0;
        r_round_en     <= 1'b0;
        r_round_idx    <= '0;
        r_digest_valid <= 1'b0;
        r_busy         <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              if (bus.block_count != '0) begin
                r_state       <= ST_WAIT_BLK;
                r_blocks_left <= bus.block_count;
                r_first       <= 1'b1;
                r_blk_ready   <= 1'b1;
                r_busy        <= 1'b1;
              end else begin
                r_err_count0  <= 1'b1;
              end
            end
          end

          ST_WAIT_BLK: begin
            if (bus.blk_valid) begin
              r_state      <= ST_LOAD;
              r_blk_ready  <= 1'b0;
              r_sched_load <= 1'b1;
              r_init_hash  <= r_first;
              r_lat_cnt    <= '0;
            end
          end

          ST_LOAD: begin
            if (r_lat_cnt == LAT_LAST) begin
              r_state     <= ST_ROUNDS;
              r_round_en  <= 1'b1;
              r_round_idx <= '0;
            end else begin
              r_lat_cnt   <= r_lat_cnt + LAT_W'(1);
            end
          end

          ST_ROUNDS: begin
            if (r_round_idx == IDX_LAST) begin
              r_state       <= ST_UPDATE;
              r_round_en    <= 1'b0;
              r_round_idx   <= '0;
              r_hash_update <= 1'b1;
            end else begin
              r_round_idx   <= r_round_idx + ROUND_IDX_W'(1);
            end
          end

          ST_UPDATE: begin
            r_blocks_left <= r_blocks_left - BC_W'(1);
            r_first       <= 1'b0;
            if (r_blocks_left == BC_W'(1)) begin
              r_state        <= ST_DONE;
              r_digest_valid <= 1'b1;
            end else begin
              r_state        <= ST_WAIT_BLK;
              r_blk_ready    <= 1'b1;
            end
          end

          ST_DONE: begin
            if (bus.digest_ack) begin
              r_state        <= ST_IDLE;
              r_digest_valid <= 1'b0;
              r_busy         <= 1'b0;
            end
          end

          default: begin
            r_state        <= ST_IDLE;
            r_blk_ready    <= 1'b0;
            r_round_en     <= 1'b0;
            r_round_idx    <= '0;
            r_digest_valid <= 1'b0;
            r_busy         <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.blk_ready    = r_blk_ready;
  assign bus.sched_load   = r_sched_load;
  assign bus.init_hash    = r_init_hash;
  assign bus.round_en     = r_round_en;
  assign bus.round_idx    = r_round_idx;
  assign bus.hash_update  = r_hash_update;
  assign bus.digest_valid = r_digest_valid;
  assign bus.busy         = r_busy;
  assign bus.err_count0   = r_err_count0;

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_block_controller
// Purpose  : Self-checking bench for sha256_block_controller. A timeline model
//            (cycles elapsed since each block handshake) predicts every output
//            each cycle; a scenario table adds per-hash totals.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_block_controller;
  import sha256_block_controller_pkg::*;

  localparam int RND   = 64;
  localparam int LAT   = 1;
  localparam int UPD_K = LAT + RND + 1;   // handshake-relative cycle of hash_update

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_BLK  = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha256_block_controller_if #(.BC_W(2)) bus ();

  sha256_block_controller #(
    .ROUNDS   (RND),
    .SCHED_LAT(LAT),
    .BC_W     (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: hash phase plus cycles since the block handshake.
  int m_mode;
  int m_k;
  int m_left;
  bit m_first;
  bit m_err;

  // Strobe tallies taken from the DUT per scenario.
  int hu_cnt, dig_cnt, sl_cnt, ih_cnt, err_cnt, busy_cnt;
  bit prev_dv;

  typedef struct {
    int count;
    int valid_delay;   // wait cycles before blk_valid on non-first blocks
    int abort_round;   // -1: none
    int start_round;   // -1: none; stray start while busy
    int exp_hu;
    int exp_dig;
    int exp_sl;
    int exp_ih;
    int exp_err;
    int exp_busy;
  } scen_t;

  scen_t scens [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_k     = 0;
    m_left  = 0;
    m_first = 1'b0;
    m_err   = 1'b0;
  endtask

  function automatic logic [13:0] model_out();
    logic br, sl, ih, re, hu, dv, bz;
    logic [5:0] idx;
    br  = (m_mode == M_WAIT);
    sl  = (m_mode == M_BLK) && (m_k == 1);
    ih  = sl && m_first;
    re  = (m_mode == M_BLK) && (m_k >= LAT + 1) && (m_k <= LAT + RND);
    idx = re ? 6'(m_k - LAT - 1) : 6'd0;
    hu  = (m_mode == M_BLK) && (m_k == UPD_K);
    dv  = (m_mode == M_DONE);
    bz  = (m_mode != M_IDLE);
    return {br, sl, ih, re, idx, hu, dv, bz, m_err};
  endfunction

  function automatic logic [13:0] dut_out();
    return {bus.blk_ready, bus.sched_load, bus.init_hash, bus.round_en, bus.round_idx,
            bus.hash_update, bus.digest_valid, bus.busy, bus.err_count0};
  endfunction

  task automatic model_step();
    bit nerr;
    nerr = 1'b0;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_mode == M_IDLE) begin
      if (bus.start) begin
        if (bus.block_count == 2'd0) nerr = 1'b1;
        else begin
          m_mode  = M_WAIT;
          m_left  = int'(bus.block_count);
          m_first = 1'b1;
        end
      end
    end else if (bus.abort) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_WAIT) begin
      if (bus.blk_valid) begin
        m_mode = M_BLK;
        m_k    = 1;
      end
    end else if (m_mode == M_BLK) begin
      if (m_k == UPD_K) begin
        m_left--;
        m_first = 1'b0;
        m_mode  = (m_left == 0) ? M_DONE : M_WAIT;
      end else begin
        m_k++;
      end
    end else if (bus.digest_ack) begin
      m_mode = M_IDLE;
    end
    m_err = nerr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cycle_outputs", 32'(dut_out()), 32'(model_out()));
    if (bus.hash_update) hu_cnt++;
    if (bus.sched_load) sl_cnt++;
    if (bus.init_hash) ih_cnt++;
    if (bus.err_count0) err_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.digest_valid && !prev_dv) dig_cnt++;
    prev_dv = bus.digest_valid;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.block_count = 2'd0;
    bus.abort       = 1'b0;
    bus.blk_valid   = 1'b0;
    bus.digest_ack  = 1'b0;
  endtask

  task automatic run_scen(input scen_t s, input int id);
    int wait_cyc;
    int done_cyc;
    bit finished;
    hu_cnt = 0; dig_cnt = 0; sl_cnt = 0; ih_cnt = 0; err_cnt = 0; busy_cnt = 0;
    wait_cyc = 0; done_cyc = 0; finished = 1'b0;
    idle_inputs();
    bus.start       = 1'b1;
    bus.block_count = 2'(s.count);
    tick();
    idle_inputs();
    for (int c = 0; c < 800; c++) begin
      if (m_mode == M_IDLE) begin
        finished = 1'b1;
        break;
      end
      bus.blk_valid   = (m_mode == M_WAIT) && (m_first || wait_cyc >= s.valid_delay);
      bus.abort       = (s.abort_round >= 0) && (m_mode == M_BLK) && (m_k - LAT - 1 == s.abort_round);
      bus.start       = (s.start_round >= 0) && (m_mode == M_BLK) && (m_k - LAT - 1 == s.start_round);
      bus.block_count = 2'd0;
      bus.digest_ack  = (m_mode == M_DONE) && (done_cyc == 2);
      wait_cyc = (m_mode == M_WAIT) ? wait_cyc + 1 : 0;
      done_cyc = (m_mode == M_DONE) ? done_cyc + 1 : 0;
      tick();
    end
    idle_inputs();
    check($sformatf("s%0d_completes", id), 32'(finished), 32'd1);
    check($sformatf("s%0d_hash_updates", id), 32'(hu_cnt), 32'(s.exp_hu));
    check($sformatf("s%0d_digests", id), 32'(dig_cnt), 32'(s.exp_dig));
    check($sformatf("s%0d_sched_loads", id), 32'(sl_cnt), 32'(s.exp_sl));
    check($sformatf("s%0d_init_hash", id), 32'(ih_cnt), 32'(s.exp_ih));
    check($sformatf("s%0d_err_count0", id), 32'(err_cnt), 32'(s.exp_err));
    check($sformatf("s%0d_busy_cycles", id), 32'(busy_cnt), 32'(s.exp_busy));
    tick();
    tick();
  endtask

  initial begin
    bit reached;
    // Busy cycles: per block WAIT+LOAD+64 rounds+UPDATE, plus extra wait
    // cycles, plus three DONE cycles (ack raised on the third).
    scens[0] = '{count:1, valid_delay:0, abort_round:-1, start_round:10,
                 exp_hu:1, exp_dig:1, exp_sl:1, exp_ih:1, exp_err:0, exp_busy:70};
    scens[1] = '{count:2, valid_delay:5, abort_round:-1, start_round:-1,
                 exp_hu:2, exp_dig:1, exp_sl:2, exp_ih:1, exp_err:0, exp_busy:142};
    scens[2] = '{count:3, valid_delay:0, abort_round:-1, start_round:-1,
                 exp_hu:3, exp_dig:1, exp_sl:3, exp_ih:1, exp_err:0, exp_busy:204};
    scens[3] = '{count:0, valid_delay:0, abort_round:-1, start_round:-1,
                 exp_hu:0, exp_dig:0, exp_sl:0, exp_ih:0, exp_err:1, exp_busy:0};
    scens[4] = '{count:1, valid_delay:0, abort_round:40, start_round:-1,
                 exp_hu:0, exp_dig:0, exp_sl:1, exp_ih:1, exp_err:0, exp_busy:43};
    scens[5] = '{count:2, valid_delay:0, abort_round:63, start_round:-1,
                 exp_hu:0, exp_dig:0, exp_sl:1, exp_ih:1, exp_err:0, exp_busy:66};

    prev_dv = 1'b0;
    model_reset();
    idle_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check("reset_state", 32'(dut_out()), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_scen(scens[i], i);

    // Asynchronous reset in the middle of round 20.
    idle_inputs();
    bus.start       = 1'b1;
    bus.block_count = 2'd1;
    tick();
    idle_inputs();
    reached = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (m_mode == M_BLK && m_k - LAT - 1 == 20) begin
        reached = 1'b1;
        break;
      end
      bus.blk_valid = (m_mode == M_WAIT);
      tick();
    end
    bus.blk_valid = 1'b0;
    check("reach_round20", 32'(reached), 32'd1);
    check("round20_idx", 32'(bus.round_idx), 32'd20);
    #3 reset = 1'b0;
    #1 check("async_reset_outputs", 32'(dut_out()), 32'd0);
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    tick();
    run_scen(scens[0], 6);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.start       = ($urandom_range(0, 15) == 0);
      bus.block_count = 2'($urandom_range(0, 3));
      bus.abort       = ($urandom_range(0, 149) == 0);
      bus.blk_valid   = $urandom_range(0, 1) == 1;
      bus.digest_ack  = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
